// File: rtl/traffic_lane_engine.sv
// Obstacle motion engine: one fixed-point phase accumulator per lane, swept one lane per clock.
// Optional difficulty ramp on level_up is compiled in with TRAFFIC_SPEED_RAMP_EN.
module traffic_lane_engine #(
   parameter int NUM_LANES     = 6,
   parameter int OBJS_PER_LANE = 10,
   parameter int SCREEN_WIDTH  = 640,
   parameter int OBJ_WIDTH     = 32,
   parameter int OBJ_HEIGHT    = 32,
   parameter int LANE_PITCH    = 64,
   parameter int Y_OFFSET      = 2,
   parameter int FRAC_BITS     = 4,
   parameter int MIN_SPEED     = 12,
   parameter int MAX_SPEED     = 24,
   parameter int SPEED_STEP    = 2,
   parameter int SPEED_CAP     = 64,
   parameter logic [NUM_LANES-1:0] DIR_PATTERN = NUM_LANES'('b101010)
) (
   input  logic              CLOCK_50,
   input  logic              reset_n,
   input  logic [1:0]        gameState,
   input  logic              frame_start,
   input  logic              level_up,
   input  logic [9:0]        rnd,
   output logic signed [10:0] obstacle_x [NUM_LANES][OBJS_PER_LANE],
   output logic [8:0]        obstacle_y [NUM_LANES],
   output logic              direction [NUM_LANES],
   output logic              busy,
   output logic              update_done,
   output logic              frame_overrun,
   output logic [1:0]        fsm_state
);

   localparam int TOTAL_WIDTH = SCREEN_WIDTH + OBJ_WIDTH;
   localparam int PH_MAX      = TOTAL_WIDTH << FRAC_BITS;
   localparam int PH_W        = $clog2(PH_MAX);
   localparam int K_W         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int SPAN        = MAX_SPEED - MIN_SPEED + 1;
   localparam logic [K_W-1:0] LAST_K = K_W'(NUM_LANES - 1);
   localparam logic [1:0]     PLAY   = 2'b01;

   // Handshake: frame_start is a fire-and-forget pulse accepted only when busy is low;
   // update_done is a one-cycle pulse with no back-pressure.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_INIT   = 2'd1,
      S_UPDATE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t         state;
   logic [K_W-1:0] k;
   logic [1:0]     prev_gs;

   logic [PH_W-1:0] phase [NUM_LANES];
   logic [7:0]      speed [NUM_LANES];

   logic [PH_W-1:0] cur_phase;
   logic [PH_W-1:0] upd_phase;
   logic [PH_W-1:0] new_phase;
   logic [PH_W:0]   fwd_sum;
   logic [7:0]      cur_speed;
   logic [7:0]      rnd_mod;
   logic [7:0]      init_speed;

   // Left edge of obstacle c for a given lane phase; spawn offsets wrap once around the track.
   function automatic logic signed [10:0] lane_x(input logic [PH_W-1:0] ph, input int c);
      logic [10:0] p;
      p = 11'(ph >> FRAC_BITS) + 11'(c * TOTAL_WIDTH / OBJS_PER_LANE);
      if (p >= 11'(TOTAL_WIDTH)) p = p - 11'(TOTAL_WIDTH);
      return $signed(p - 11'(OBJ_WIDTH));
   endfunction

`ifdef TRAFFIC_SPEED_RAMP_EN
   function automatic logic [7:0] ramp_speed(input logic [7:0] s);
      logic [8:0] r;
      r = {1'b0, s} + 9'(SPEED_STEP);
      if (r > 9'(SPEED_CAP)) r = 9'(SPEED_CAP);
      return r[7:0];
   endfunction
`else
   logic level_up_unused;
   assign level_up_unused = level_up;
`endif

   always_comb begin
      cur_phase = phase[k];
      cur_speed = speed[k];
      fwd_sum   = {1'b0, cur_phase} + (PH_W+1)'(cur_speed);
      upd_phase = cur_phase;
      if (DIR_PATTERN[k]) begin
         if (cur_phase < PH_W'(cur_speed))
            upd_phase = PH_W'(({1'b0, cur_phase} + (PH_W+1)'(PH_MAX)) - (PH_W+1)'(cur_speed));
         else
            upd_phase = cur_phase - PH_W'(cur_speed);
      end else begin
         if (fwd_sum >= (PH_W+1)'(PH_MAX))
            upd_phase = PH_W'(fwd_sum - (PH_W+1)'(PH_MAX));
         else
            upd_phase = fwd_sum[PH_W-1:0];
      end
      new_phase  = (state == S_INIT) ? '0 : upd_phase;
      rnd_mod    = 8'(rnd % 10'(SPAN));
      init_speed = 8'(MIN_SPEED) + rnd_mod;
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         k             <= '0;
         prev_gs       <= 2'b00;
         busy          <= 1'b0;
         update_done   <= 1'b0;
         frame_overrun <= 1'b0;
      end else begin
         prev_gs     <= gameState;
         update_done <= (state == S_DONE);
         if (frame_start && busy) frame_overrun <= 1'b1;
         case (state)
            S_IDLE: begin
               // Play entry wins over a coincident frame_start.
               if (gameState == PLAY && prev_gs != PLAY) begin
                  state <= S_INIT;
                  k     <= '0;
                  busy  <= 1'b1;
               end else if (frame_start && gameState == PLAY) begin
                  state <= S_UPDATE;
                  k     <= '0;
                  busy  <= 1'b1;
               end
            end
            S_INIT: begin
               if (k == LAST_K) begin
                  state <= S_IDLE;
                  k     <= '0;
                  busy  <= 1'b0;
               end else begin
                  k <= k + 1'b1;
               end
            end
            S_UPDATE: begin
               if (k == LAST_K) begin
                  state <= S_DONE;
                  k     <= '0;
               end else begin
                  k <= k + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            phase[i] <= '0;
            speed[i] <= 8'(MIN_SPEED);
            for (int c = 0; c < OBJS_PER_LANE; c++)
               obstacle_x[i][c] <= lane_x('0, c);
         end
      end else begin
`ifdef TRAFFIC_SPEED_RAMP_EN
         if (level_up)
            for (int i = 0; i < NUM_LANES; i++)
               speed[i] <= ramp_speed(speed[i]);
`endif
         // Later assignment gives the INIT speed priority over a same-cycle ramp.
         if (state == S_INIT || state == S_UPDATE) begin
            phase[k] <= new_phase;
            for (int c = 0; c < OBJS_PER_LANE; c++)
               obstacle_x[k][c] <= lane_x(new_phase, c);
            if (state == S_INIT) speed[k] <= init_speed;
         end
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign obstacle_y[i] = 9'(Y_OFFSET + (NUM_LANES - 1 - i) * LANE_PITCH
                                + LANE_PITCH / 4 - OBJ_HEIGHT / 2);
      assign direction[i]  = DIR_PATTERN[i];
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_traffic_lane_engine.sv
// Directed bench for traffic_lane_engine; expectations follow TRAFFIC_SPEED_RAMP_EN when defined.
module tb_traffic_lane_engine;

   logic              CLOCK_50 = 1'b0;
   logic              reset_n = 1'b0;
   logic [1:0]        gameState = 2'b00;
   logic              frame_start = 1'b0;
   logic              level_up = 1'b0;
   logic [9:0]        rnd = '0;
   logic signed [10:0] obstacle_x [6][10];
   logic [8:0]        obstacle_y [6];
   logic              direction [6];
   logic              busy;
   logic              update_done;
   logic              frame_overrun;
   logic [1:0]        fsm_state;

   int checks = 0;
   int failures = 0;

   traffic_lane_engine dut (
      .CLOCK_50      (CLOCK_50),
      .reset_n       (reset_n),
      .gameState     (gameState),
      .frame_start   (frame_start),
      .level_up      (level_up),
      .rnd           (rnd),
      .obstacle_x    (obstacle_x),
      .obstacle_y    (obstacle_y),
      .direction     (direction),
      .busy          (busy),
      .update_done   (update_done),
      .frame_overrun (frame_overrun),
      .fsm_state     (fsm_state)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge CLOCK_50);
      #1;
   endtask

   // One frame_start pulse, then wait (bounded) for update_done.
   task automatic run_sweeps(input int n);
      bit seen;
      for (int s = 0; s < n; s++) begin
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         seen = 1'b0;
         for (int j = 0; j < 20 && !seen; j++) begin
            tick();
            if (update_done) seen = 1'b1;
         end
         if (!seen) begin
            checks++; failures++;
            $display("FAIL sweep_timeout got=no_done exp=done sweep=%0d", s);
         end
      end
   endtask

   task automatic enter_play(input logic [9:0] r);
      gameState = 2'b00;
      rnd = r;
      tick();
      gameState = 2'b01;
      tick();
      repeat (7) tick();
   endtask

   task automatic test_reset;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
      checks++; if (update_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", update_done); end
      checks++; if (frame_overrun !== 1'b0) begin failures++; $display("FAIL rst_ovr got=%0b exp=0", frame_overrun); end
      checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", fsm_state); end
      checks++; if (obstacle_x[0][0] !== -11'sd32) begin failures++; $display("FAIL rst_x00 got=%0d exp=-32", obstacle_x[0][0]); end
      checks++; if (obstacle_x[0][1] !== 11'sd35) begin failures++; $display("FAIL rst_x01 got=%0d exp=35", obstacle_x[0][1]); end
      checks++; if (obstacle_x[5][9] !== 11'sd572) begin failures++; $display("FAIL rst_x59 got=%0d exp=572", obstacle_x[5][9]); end
      checks++; if (obstacle_y[0] !== 9'd322) begin failures++; $display("FAIL rst_y0 got=%0d exp=322", obstacle_y[0]); end
      checks++; if (obstacle_y[5] !== 9'd2) begin failures++; $display("FAIL rst_y5 got=%0d exp=2", obstacle_y[5]); end
      checks++; if (direction[0] !== 1'b0) begin failures++; $display("FAIL rst_dir0 got=%0b exp=0", direction[0]); end
      checks++; if (direction[1] !== 1'b1) begin failures++; $display("FAIL rst_dir1 got=%0b exp=1", direction[1]); end
   endtask

   task automatic test_idle_frame_ignored;
      gameState = 2'b00;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", busy); end
      checks++; if (frame_overrun !== 1'b0) begin failures++; $display("FAIL idle_ovr got=%0b exp=0", frame_overrun); end
   endtask

   task automatic test_play_entry;
      int done_cnt;
      logic busy5, busy6;
      gameState = 2'b00;
      rnd = '0;
      tick();
      gameState = 2'b01;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      checks++; if (fsm_state !== 2'd1) begin failures++; $display("FAIL entry_state got=%0d exp=1", fsm_state); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL entry_busy got=%0b exp=1", busy); end
      done_cnt = 0;
      busy5 = 1'b0;
      busy6 = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         tick();
         if (update_done) done_cnt++;
         if (j == 5) busy5 = busy;
         if (j == 6) busy6 = busy;
      end
      checks++; if (busy5 !== 1'b1) begin failures++; $display("FAIL init_busy5 got=%0b exp=1", busy5); end
      checks++; if (busy6 !== 1'b0) begin failures++; $display("FAIL init_busy6 got=%0b exp=0", busy6); end
      checks++; if (done_cnt != 0) begin failures++; $display("FAIL init_done got=%0d exp=0", done_cnt); end
      checks++; if (frame_overrun !== 1'b0) begin failures++; $display("FAIL init_ovr got=%0b exp=0", frame_overrun); end
   endtask

   task automatic test_right_motion;
      run_sweeps(1);
      checks++; if (obstacle_x[0][0] !== -11'sd32) begin failures++; $display("FAIL mv1_x00 got=%0d exp=-32", obstacle_x[0][0]); end
      checks++; if (obstacle_x[1][0] !== 11'sd639) begin failures++; $display("FAIL mv1_x10 got=%0d exp=639", obstacle_x[1][0]); end
      run_sweeps(3);
      checks++; if (obstacle_x[0][0] !== -11'sd29) begin failures++; $display("FAIL mv4_x00 got=%0d exp=-29", obstacle_x[0][0]); end
      checks++; if (obstacle_x[0][9] !== 11'sd575) begin failures++; $display("FAIL mv4_x09 got=%0d exp=575", obstacle_x[0][9]); end
      checks++; if (obstacle_x[1][0] !== 11'sd637) begin failures++; $display("FAIL mv4_x10 got=%0d exp=637", obstacle_x[1][0]); end
      checks++; if (obstacle_x[1][5] !== 11'sd301) begin failures++; $display("FAIL mv4_x15 got=%0d exp=301", obstacle_x[1][5]); end
   endtask

   task automatic test_wrap;
      run_sweeps(891);
      checks++; if (obstacle_x[0][0] !== 11'sd639) begin failures++; $display("FAIL wrap895_x00 got=%0d exp=639", obstacle_x[0][0]); end
      checks++; if (obstacle_x[0][1] !== 11'sd34) begin failures++; $display("FAIL wrap895_x01 got=%0d exp=34", obstacle_x[0][1]); end
      run_sweeps(1);
      checks++; if (obstacle_x[0][0] !== -11'sd32) begin failures++; $display("FAIL wrap896_x00 got=%0d exp=-32", obstacle_x[0][0]); end
      checks++; if (obstacle_x[0][9] !== 11'sd572) begin failures++; $display("FAIL wrap896_x09 got=%0d exp=572", obstacle_x[0][9]); end
      checks++; if (obstacle_x[1][1] !== 11'sd35) begin failures++; $display("FAIL wrap896_x11 got=%0d exp=35", obstacle_x[1][1]); end
   endtask

   task automatic test_speed_mod;
      enter_play(10'd12);
      run_sweeps(3);
      checks++; if (obstacle_x[0][0] !== -11'sd28) begin failures++; $display("FAIL rnd12_x00 got=%0d exp=-28", obstacle_x[0][0]); end
      checks++; if (obstacle_x[1][0] !== 11'sd635) begin failures++; $display("FAIL rnd12_x10 got=%0d exp=635", obstacle_x[1][0]); end
      enter_play(10'd13);
      checks++; if (obstacle_x[0][0] !== -11'sd32) begin failures++; $display("FAIL init_x00 got=%0d exp=-32", obstacle_x[0][0]); end
      checks++; if (obstacle_x[1][3] !== 11'sd169) begin failures++; $display("FAIL init_x13 got=%0d exp=169", obstacle_x[1][3]); end
      run_sweeps(3);
      checks++; if (obstacle_x[0][0] !== -11'sd30) begin failures++; $display("FAIL rnd13_x00 got=%0d exp=-30", obstacle_x[0][0]); end
      checks++; if (obstacle_x[5][0] !== 11'sd637) begin failures++; $display("FAIL rnd13_x50 got=%0d exp=637", obstacle_x[5][0]); end
      enter_play(10'd1023);
      run_sweeps(3);
      checks++; if (obstacle_x[4][0] !== -11'sd29) begin failures++; $display("FAIL rnd1023_x40 got=%0d exp=-29", obstacle_x[4][0]); end
      checks++; if (obstacle_x[1][0] !== 11'sd636) begin failures++; $display("FAIL rnd1023_x10 got=%0d exp=636", obstacle_x[1][0]); end
   endtask

   task automatic test_level_up;
      logic signed [10:0] exp0, exp1;
`ifdef TRAFFIC_SPEED_RAMP_EN
      exp0 = -11'sd24;
      exp1 = 11'sd632;
`else
      exp0 = -11'sd31;
      exp1 = 11'sd638;
`endif
      enter_play(10'd0);
      for (int j = 0; j < 40; j++) begin
         level_up = 1'b1;
         tick();
         level_up = 1'b0;
         tick();
      end
      run_sweeps(2);
      checks++; if (obstacle_x[0][0] !== exp0) begin failures++; $display("FAIL ramp_x00 got=%0d exp=%0d", obstacle_x[0][0], exp0); end
      checks++; if (obstacle_x[1][0] !== exp1) begin failures++; $display("FAIL ramp_x10 got=%0d exp=%0d", obstacle_x[1][0], exp1); end
   endtask

   task automatic test_gamestate_leave;
      logic signed [10:0] exp0;
      bit seen;
`ifdef TRAFFIC_SPEED_RAMP_EN
      exp0 = -11'sd20;
`else
      exp0 = -11'sd30;
`endif
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      gameState = 2'b00;
      seen = 1'b0;
      for (int j = 0; j < 20 && !seen; j++) begin
         tick();
         if (update_done) seen = 1'b1;
      end
      checks++; if (!seen) begin failures++; $display("FAIL leave_done got=0 exp=1"); end
      checks++; if (obstacle_x[0][0] !== exp0) begin failures++; $display("FAIL leave_x00 got=%0d exp=%0d", obstacle_x[0][0], exp0); end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL leave_nosweep got=%0b exp=0", busy); end
   endtask

   task automatic test_back_to_back;
      int done_cnt, first_n;
      logic busy6, busy7;
      enter_play(10'd0);
      checks++; if (frame_overrun !== 1'b0) begin failures++; $display("FAIL b2b_pre_ovr got=%0b exp=0", frame_overrun); end
      frame_start = 1'b1;
      tick();
      tick();
      frame_start = 1'b0;
      checks++; if (frame_overrun !== 1'b1) begin failures++; $display("FAIL b2b_ovr got=%0b exp=1", frame_overrun); end
      done_cnt = 0;
      first_n = -1;
      busy6 = 1'b0;
      busy7 = 1'b1;
      for (int n = 2; n <= 14; n++) begin
         tick();
         if (update_done) begin
            done_cnt++;
            if (first_n < 0) first_n = n;
         end
         if (n == 6) busy6 = busy;
         if (n == 7) busy7 = busy;
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL b2b_done_cnt got=%0d exp=1", done_cnt); end
      checks++; if (first_n != 7) begin failures++; $display("FAIL b2b_done_lat got=%0d exp=7", first_n); end
      checks++; if (busy6 !== 1'b1) begin failures++; $display("FAIL b2b_busy6 got=%0b exp=1", busy6); end
      checks++; if (busy7 !== 1'b0) begin failures++; $display("FAIL b2b_busy7 got=%0b exp=0", busy7); end
      checks++; if (obstacle_x[1][0] !== 11'sd639) begin failures++; $display("FAIL b2b_x10 got=%0d exp=639", obstacle_x[1][0]); end
      run_sweeps(1);
      checks++; if (frame_overrun !== 1'b1) begin failures++; $display("FAIL b2b_sticky got=%0b exp=1", frame_overrun); end
   endtask

   task automatic test_reset_mid_sweep;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mrst_busy got=%0b exp=0", busy); end
      checks++; if (obstacle_x[0][1] !== 11'sd35) begin failures++; $display("FAIL mrst_x01 got=%0d exp=35", obstacle_x[0][1]); end
      checks++; if (obstacle_x[0][0] !== -11'sd32) begin failures++; $display("FAIL mrst_x00 got=%0d exp=-32", obstacle_x[0][0]); end
      checks++; if (obstacle_y[5] !== 9'd2) begin failures++; $display("FAIL mrst_y5 got=%0d exp=2", obstacle_y[5]); end
      checks++; if (frame_overrun !== 1'b0) begin failures++; $display("FAIL mrst_ovr got=%0b exp=0", frame_overrun); end
      checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL mrst_state got=%0d exp=0", fsm_state); end
      reset_n = 1'b1;
      tick();
      // gameState is still PLAY and the previous-state register restarted at 00.
      checks++; if (fsm_state !== 2'd1) begin failures++; $display("FAIL mrst_reentry got=%0d exp=1", fsm_state); end
   endtask

   initial begin
      reset_n = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      #2;
      reset_n = 1'b1;
      tick();
      test_reset();
      test_idle_frame_ignored();
      test_play_entry();
      test_right_motion();
      test_wrap();
      test_speed_mod();
      test_level_up();
      test_gamestate_leave();
      test_back_to_back();
      test_reset_mid_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
